// File: rtl/blake2s_block_buffer_pkg.sv
// Shared constants and bank state encoding for the BLAKE2s message block buffer.
package blake2s_block_buffer_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned WORD_W      = 32;
  localparam logic [63:0] T_INC       = 64'd64;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/blake2s_block_bank.sv
// One ping-pong bank: block storage with byte write port, fill state,
// first/last flags and the byte counter captured at completion.
module blake2s_block_bank #(
  parameter  int unsigned BLOCK_BYTES = blake2s_block_buffer_pkg::BLOCK_BYTES,
  localparam int unsigned IDX_W       = $clog2(BLOCK_BYTES)
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_data,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic [63:0]              i_t,
  input  logic                     i_clr,
  output logic                     o_full,
  output logic [BLOCK_BYTES*8-1:0] o_m,
  output logic [63:0]              o_t,
  output logic                     o_first,
  output logic                     o_last
);
  import blake2s_block_buffer_pkg::*;

  bank_state_e              r_state;
  bank_state_e              w_state_nxt;
  logic [BLOCK_BYTES*8-1:0] r_m;
  logic [63:0]              r_t;
  logic                     r_first;
  logic                     r_last;
  logic                     w_complete;

  assign w_complete = i_wr_en && (i_wr_idx == IDX_W'(BLOCK_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!nreset) r_state <= BANK_EMPTY;
    else         r_state <= w_state_nxt;
  end

  // Clear and write never target the same bank: a write needs a non-full bank,
  // a clear needs a full one.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clr)        w_state_nxt = BANK_EMPTY;
    else if (i_wr_en) w_state_nxt = w_complete ? BANK_FULL : BANK_FILLING;
  end

  always_comb begin
    o_full = (r_state == BANK_FULL);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_t     <= '0;
    end else if (i_clr) begin
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_t     <= '0;
    end else if (i_wr_en) begin
      r_first <= r_first | i_first;
      r_last  <= r_last  | i_last;
      if (w_complete) r_t <= i_t;
    end
  end

  // Storage is intentionally not reset; unwritten bytes keep prior content.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_m[{i_wr_idx, 3'b000} +: 8] <= i_wr_data;
  end

  assign o_m     = r_m;
  assign o_t     = r_t;
  assign o_first = r_first;
  assign o_last  = r_last;

endmodule

// File: rtl/blake2s_block_buffer.sv
// Ping-pong byte-to-block buffer feeding the BLAKE2s compression core, with
// byte counter t generation and sticky overflow on dropped bytes.
module blake2s_block_buffer #(
  parameter  int unsigned BLOCK_BYTES = blake2s_block_buffer_pkg::BLOCK_BYTES,
  parameter  int unsigned WORD_W      = blake2s_block_buffer_pkg::WORD_W,
  localparam int unsigned IDX_W       = $clog2(BLOCK_BYTES),
  localparam int unsigned M_W         = (BLOCK_BYTES * 8 / WORD_W) * WORD_W
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             data_v_i,
  input  logic [7:0]       data_i,
  input  logic [IDX_W-1:0] data_idx_i,
  input  logic             block_first_i,
  input  logic             block_last_i,
  input  logic [63:0]      ll_i,
  output logic             blk_v_o,
  input  logic             blk_ready_i,
  output logic [M_W-1:0]   blk_m_o,
  output logic [63:0]      blk_t_o,
  output logic             blk_first_o,
  output logic             blk_last_o,
  output logic             overflow_o
);
  import blake2s_block_buffer_pkg::*;

  logic                     r_wr_q;
  logic                     r_rd_q;
  logic [63:0]              r_t_run;
  logic                     r_overflow;

  logic [1:0]               w_full;
  logic [1:0]               w_first;
  logic [1:0]               w_last;
  logic [BLOCK_BYTES*8-1:0] w_m [2];
  logic [63:0]              w_t [2];
  logic [1:0]               w_wr_en;
  logic [1:0]               w_clr;
  logic                     w_accept;
  logic                     w_complete;
  logic                     w_xfer;
  logic                     w_first_acc;
  logic                     w_last_acc;
  logic [63:0]              w_t_new;

  assign w_accept    = data_v_i & ~w_full[r_wr_q];
  assign w_complete  = w_accept & (data_idx_i == IDX_W'(BLOCK_BYTES - 1));
  assign w_xfer      = w_full[r_rd_q] & blk_ready_i;
  // Flags include the completing byte's own first/last marks.
  assign w_first_acc = w_first[r_wr_q] | block_first_i;
  assign w_last_acc  = w_last[r_wr_q]  | block_last_i;

  always_comb begin
    if (w_last_acc)       w_t_new = ll_i;
    else if (w_first_acc) w_t_new = T_INC;
    else                  w_t_new = r_t_run + T_INC;
  end

  always_comb begin
    w_wr_en         = '0;
    w_wr_en[r_wr_q] = w_accept;
    w_clr           = '0;
    w_clr[r_rd_q]   = w_xfer;
  end

  blake2s_block_bank #(.BLOCK_BYTES(BLOCK_BYTES)) u_bank0 (
    .clk       (clk),
    .nreset    (nreset),
    .i_wr_en   (w_wr_en[0]),
    .i_wr_data (data_i),
    .i_wr_idx  (data_idx_i),
    .i_first   (block_first_i),
    .i_last    (block_last_i),
    .i_t       (w_t_new),
    .i_clr     (w_clr[0]),
    .o_full    (w_full[0]),
    .o_m       (w_m[0]),
    .o_t       (w_t[0]),
    .o_first   (w_first[0]),
    .o_last    (w_last[0])
  );

  blake2s_block_bank #(.BLOCK_BYTES(BLOCK_BYTES)) u_bank1 (
    .clk       (clk),
    .nreset    (nreset),
    .i_wr_en   (w_wr_en[1]),
    .i_wr_data (data_i),
    .i_wr_idx  (data_idx_i),
    .i_first   (block_first_i),
    .i_last    (block_last_i),
    .i_t       (w_t_new),
    .i_clr     (w_clr[1]),
    .o_full    (w_full[1]),
    .o_m       (w_m[1]),
    .o_t       (w_t[1]),
    .o_first   (w_first[1]),
    .o_last    (w_last[1])
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_wr_q     <= 1'b0;
      r_rd_q     <= 1'b0;
      r_t_run    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_complete) begin
        r_wr_q  <= ~r_wr_q;
        r_t_run <= w_last_acc ? '0 : w_t_new;
      end
      if (w_xfer)                       r_rd_q     <= ~r_rd_q;
      if (data_v_i && w_full[r_wr_q])   r_overflow <= 1'b1;
    end
  end

  assign blk_v_o     = w_full[r_rd_q];
  assign blk_m_o     = w_m[r_rd_q];
  assign blk_t_o     = w_t[r_rd_q];
  assign blk_first_o = w_first[r_rd_q];
  assign blk_last_o  = w_last[r_rd_q];
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_blake2s_block_buffer.sv
// Directed scoreboard bench for blake2s_block_buffer.
module tb_blake2s_block_buffer;

  logic         clk = 1'b0;
  logic         nreset;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i;
  logic         block_last_i;
  logic [63:0]  ll_i;
  logic         blk_v_o;
  logic         blk_ready_i;
  logic [511:0] blk_m_o;
  logic [63:0]  blk_t_o;
  logic         blk_first_o;
  logic         blk_last_o;
  logic         overflow_o;

  typedef struct {
    logic [511:0] m;
    logic [63:0]  t;
    logic         first;
    logic         last;
  } exp_blk_t;

  exp_blk_t     sb[$];
  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [511:0] last_m;
  logic [511:0] b1, b2, b3;

  always #5 clk = ~clk;

  blake2s_block_buffer #(.BLOCK_BYTES(64), .WORD_W(32)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .data_v_i      (data_v_i),
    .data_i        (data_i),
    .data_idx_i    (data_idx_i),
    .block_first_i (block_first_i),
    .block_last_i  (block_last_i),
    .ll_i          (ll_i),
    .blk_v_o       (blk_v_o),
    .blk_ready_i   (blk_ready_i),
    .blk_m_o       (blk_m_o),
    .blk_t_o       (blk_t_o),
    .blk_first_o   (blk_first_o),
    .blk_last_o    (blk_last_o),
    .overflow_o    (overflow_o)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare any transfer at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    exp_blk_t e;
    @(negedge clk);
    if (nreset && blk_v_o && blk_ready_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_block observed t=%0h expected no block", blk_t_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("blk_m", blk_m_o, e.m);
        check("blk_t", 512'(blk_t_o), 512'(e.t));
        check("blk_first", 512'(blk_first_o), 512'(e.first));
        check("blk_last", 512'(blk_last_o), 512'(e.last));
        last_m = blk_m_o;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [511:0] m, input logic [63:0] t, input logic f, input logic l);
    exp_blk_t e;
    e.m = m; e.t = t; e.first = f; e.last = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [511:0] m, input int unsigned n, input logic f, input logic l,
                      input logic rdy_last);
    for (int unsigned i = 0; i < n; i++) begin
      data_v_i      = 1'b1;
      data_i        = m[8*i +: 8];
      data_idx_i    = 6'(i);
      block_first_i = f;
      block_last_i  = l;
      if (rdy_last && i == 63) blk_ready_i = 1'b1;
      cycle();
    end
    data_v_i      = 1'b0;
    block_first_i = 1'b0;
    block_last_i  = 1'b0;
  endtask

  task automatic drain(input int unsigned max_cycles);
    int unsigned n = 0;
    blk_ready_i = 1'b1;
    while (sb.size() != 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed %0d pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    sb.delete();
    cycle();
    cycle();
    nreset = 1'b1;
  endtask

  function automatic logic [511:0] rand_block(input int unsigned n);
    logic [511:0] b = '0;
    for (int unsigned j = 0; j < n; j++) b[8*j +: 8] = 8'($urandom);
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; data_v_i = 1'b0; data_i = '0; data_idx_i = '0;
    block_first_i = 1'b0; block_last_i = 1'b0; ll_i = '0; blk_ready_i = 1'b0;
    last_m = '0;
    cycle();
    cycle();
    check("rst_v", 512'(blk_v_o), 512'(0));
    check("rst_t", 512'(blk_t_o), 512'(0));
    check("rst_first", 512'(blk_first_o), 512'(0));
    check("rst_last", 512'(blk_last_o), 512'(0));
    check("rst_ovf", 512'(overflow_o), 512'(0));
    nreset = 1'b1;
    cycle();

    // "abc" single block
    b1 = '0;
    b1[23:0] = 24'h636261;
    ll_i = 64'd3;
    blk_ready_i = 1'b1;
    push(b1, 64'd3, 1'b1, 1'b1);
    send(b1, 64, 1'b1, 1'b1, 1'b0);
    drain(10);
    check("abc_word0", 512'(last_m[31:0]), 512'(32'h00636261));

    // 100-byte message, ready high
    ll_i = 64'd100;
    b1 = rand_block(64);
    b2 = rand_block(36);
    push(b1, 64'd64, 1'b1, 1'b0);
    push(b2, 64'd100, 1'b0, 1'b1);
    send(b1, 64, 1'b1, 1'b0, 1'b0);
    send(b2, 64, 1'b0, 1'b1, 1'b0);
    drain(10);
    check("t_run_100", 512'(dut.r_t_run), 512'(0));

    // 150-byte message: middle block uses running count
    ll_i = 64'd150;
    b1 = rand_block(64); b2 = rand_block(64); b3 = rand_block(22);
    push(b1, 64'd64, 1'b1, 1'b0);
    push(b2, 64'd128, 1'b0, 1'b0);
    push(b3, 64'd150, 1'b0, 1'b1);
    send(b1, 64, 1'b1, 1'b0, 1'b0);
    send(b2, 64, 1'b0, 1'b0, 1'b0);
    send(b3, 64, 1'b0, 1'b1, 1'b0);
    drain(10);
    check("t_run_150", 512'(dut.r_t_run), 512'(0));

    // Ready low: two blocks held, third dropped
    blk_ready_i = 1'b0;
    ll_i = 64'd192;
    b1 = rand_block(64); b2 = rand_block(64); b3 = rand_block(64);
    push(b1, 64'd64, 1'b1, 1'b0);
    push(b2, 64'd128, 1'b0, 1'b0);
    send(b1, 64, 1'b1, 1'b0, 1'b0);
    send(b2, 64, 1'b0, 1'b0, 1'b0);
    send(b3, 64, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 512'(overflow_o), 512'(1));
    check("ovf_held_v", 512'(blk_v_o), 512'(1));
    check("ovf_held_t", 512'(blk_t_o), 512'(64));
    drain(20);
    cycle(); cycle(); cycle();
    check("ovf_no_third", 512'(blk_v_o), 512'(0));
    check("ovf_sticky", 512'(overflow_o), 512'(1));
    do_reset();
    check("ovf_cleared", 512'(overflow_o), 512'(0));

    // Ready pulsed on the cycle after block 2 completes
    blk_ready_i = 1'b0;
    ll_i = 64'd128;
    b1 = rand_block(64); b2 = rand_block(64);
    push(b1, 64'd64, 1'b1, 1'b0);
    push(b2, 64'd128, 1'b0, 1'b1);
    send(b1, 64, 1'b1, 1'b0, 1'b0);
    send(b2, 64, 1'b0, 1'b1, 1'b0);
    blk_ready_i = 1'b1;
    cycle();
    blk_ready_i = 1'b0;
    check("pulse_v", 512'(blk_v_o), 512'(1));
    check("pulse_t", 512'(blk_t_o), 512'(128));
    check("pulse_last", 512'(blk_last_o), 512'(1));
    check("pulse_ovf", 512'(overflow_o), 512'(0));
    drain(10);

    // Transfer and completion on the same edge
    b1 = rand_block(64); b2 = rand_block(64);
    push(b1, 64'd64, 1'b1, 1'b0);
    push(b2, 64'd128, 1'b0, 1'b1);
    blk_ready_i = 1'b0;
    send(b1, 64, 1'b1, 1'b0, 1'b0);
    send(b2, 64, 1'b0, 1'b1, 1'b1);
    drain(10);
    check("same_edge_ovf", 512'(overflow_o), 512'(0));

    // Reset with one pending block and a partial block
    blk_ready_i = 1'b0;
    ll_i = 64'd128;
    b1 = rand_block(64); b2 = rand_block(64);
    send(b1, 64, 1'b1, 1'b0, 1'b0);
    send(b2, 30, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("mid_rst_v", 512'(blk_v_o), 512'(0));
    check("mid_rst_first", 512'(blk_first_o), 512'(0));
    check("mid_rst_t", 512'(blk_t_o), 512'(0));
    ll_i = 64'd64;
    b3 = rand_block(64);
    push(b3, 64'd64, 1'b1, 1'b1);
    blk_ready_i = 1'b1;
    send(b3, 64, 1'b1, 1'b1, 1'b0);
    drain(10);
    cycle(); cycle();
    check("end_idle_v", 512'(blk_v_o), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
